mul_hash_window_gen: RTL

Front-end window generator for the multiplicative-hash pipeline. Consumes a 64-bit byte stream of packet payload and emits one 64-bit sliding window per payload byte position. Each window is formatted as the hasher's `a` operand, with byte `i` in `a[7:0]`. It sits directly upstream of the `mul_hash`/`acc_hash` datapath and provides the position and length sideband that the downstream match logic carries alongside the hash result.

---
 rtl/mul_hash_window_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mul_hash_window_gen.sv
// mul_hash_window_gen: sliding 8-byte window generator
// feeding the multiplicative-hash datapath.
module mul_hash_window_gen #(
  parameter int POS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      s_axis_tdata,
  input  logic [7:0]       s_axis_tkeep,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [63:0]      m_win_data,
  output logic [3:0]       m_win_len,
  output logic [POS_W-1:0] m_win_pos,
  output logic             m_win_last,
  output logic             m_win_valid,
  input  logic             m_win_ready
);

  typedef enum logic [1:0] {
    FILL,
    STREAM,
    FLUSH
  } state_t;

  state_t state;

  logic [15:0][7:0] sbuf;
  logic [4:0]       cnt;
  logic [POS_W-1:0] pos;

  logic             eop;
  logic             accept;
  logic             can_emit;
  logic             shift;
  logic             is_last;
  logic [3:0]       kcnt;
  logic [4:0]       base;
  logic [4:0]       cnt_nxt;
  logic [15:0][7:0] sbuf_nxt;
  logic [63:0]      win;
  logic [3:0]       win_len;

  // the tlast beat is held in the buffer exactly while in FLUSH
  assign eop = (state == FLUSH);

  assign s_axis_tready = !eop && (cnt <= 5'd8);
  assign accept = s_axis_tvalid && s_axis_tready;

  assign can_emit = (cnt >= 5'd8)
                 || (eop && cnt != 5'd0);
  assign shift = can_emit
              && (!m_win_valid || m_win_ready);
  assign is_last = eop && (cnt == 5'd1);

  assign win_len = (cnt >= 5'd8) ? 4'd8 : cnt[3:0];

  assign cnt_nxt = cnt
                 - {4'b0, shift}
                 + (accept ? {1'b0, kcnt} : 5'd0);

  // number of kept bytes in the incoming beat
  always_comb begin
    kcnt = '0;
    for (int j = 0; j < 8; j++) begin
      kcnt = kcnt + {3'b0, s_axis_tkeep[j]};
    end
  end

  // window view of the buffer head, bytes past cnt zeroed
  always_comb begin
    win = '0;
    for (int j = 0; j < 8; j++) begin
      if (5'(j) < cnt) begin
        win[8*j +: 8] = sbuf[j];
      end
    end
  end

  // next buffer: optional 1-byte shift, then append the beat
  always_comb begin
    sbuf_nxt = sbuf;
    base = cnt;
    if (shift) begin
      sbuf_nxt = {8'h00, sbuf[15:1]};
      base = cnt - 5'd1;
    end
    if (accept) begin
      for (int j = 0; j < 8; j++) begin
        if (s_axis_tkeep[j]) begin
          sbuf_nxt[4'(base + 5'(j))] =
            s_axis_tdata[8*j +: 8];
        end
      end
    end
  end

  // control FSM: fill, stream, flush the packet tail
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      unique case (state)
        FILL: begin
          if (accept && s_axis_tlast) begin
            state <= FLUSH;
          end else if (cnt_nxt >= 5'd8) begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (accept && s_axis_tlast) begin
            state <= FLUSH;
          end else if (cnt_nxt < 5'd8) begin
            state <= FILL;
          end
        end
        FLUSH: begin
          if (cnt == 5'd0 || (shift && is_last)) begin
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // byte buffer, occupancy and position counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sbuf <= '0;
      cnt  <= '0;
      pos  <= '0;
    end else begin
      sbuf <= sbuf_nxt;
      cnt  <= cnt_nxt;
      if (shift) begin
        pos <= is_last ? '0 : pos + POS_W'(1);
      end else if (eop && cnt == 5'd0) begin
        pos <= '0;
      end
    end
  end

  // registered window output with valid/ready hold
  always_ff @(posedge clk) begin
    if (rst) begin
      m_win_valid <= 1'b0;
      m_win_data  <= '0;
      m_win_len   <= '0;
      m_win_pos   <= '0;
      m_win_last  <= 1'b0;
    end else if (shift) begin
      m_win_valid <= 1'b1;
      m_win_data  <= win;
      m_win_len   <= win_len;
      m_win_pos   <= pos;
      m_win_last  <= is_last;
    end else if (m_win_ready) begin
      m_win_valid <= 1'b0;
    end
  end

endmodule
